// File: rtl/issue_sched_pkg.sv
// Shared types and defaults for the issue scheduler and its writeback arbiter.
package issue_sched_pkg;

    typedef enum logic [1:0] {
        SchedRun   = 2'd0,
        SchedDrain = 2'd1,
        SchedFlush = 2'd2
    } sched_state_e;

    typedef enum logic [1:0] {
        WbSelAlu = 2'd0,
        WbSelLsu = 2'd1,
        WbSelMdu = 2'd2
    } wb_sel_e;

    localparam int unsigned MaxOutDefault = 4;

endpackage

// File: rtl/issue_sched_wb_rr_arb.sv
// Two-requester round-robin arbiter (a = LSU, b = MDU) with a high-priority override (ALU).
module wb_rr_arb
    import issue_sched_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_hp_req,
    input  logic       i_req_a,
    input  logic       i_req_b,
    output logic       o_gnt_hp,
    output logic       o_gnt_a,
    output logic       o_gnt_b,
    output logic [1:0] o_sel
);

    // Set when b holds priority for the next contested cycle.
    logic r_ptr_b;

    always_comb begin
        o_gnt_hp = i_hp_req;
        o_gnt_a  = ~i_hp_req & i_req_a & (~i_req_b | ~r_ptr_b);
        o_gnt_b  = ~i_hp_req & i_req_b & (~i_req_a | r_ptr_b);
        o_sel    = WbSelAlu;
        if (o_gnt_a) begin
            o_sel = WbSelLsu;
        end else if (o_gnt_b) begin
            o_sel = WbSelMdu;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptr_b <= 1'b0;
        end else if (o_gnt_a) begin
            r_ptr_b <= 1'b1;
        end else if (o_gnt_b) begin
            r_ptr_b <= 1'b0;
        end
    end

endmodule

// File: rtl/issue_sched.sv
// ID->EX issue scheduler with long-latency scoreboard and regfile write-port arbitration.
// Optional stall performance counters are built when ISSUE_SCHED_PERF_EN is defined.
module issue_sched
    import issue_sched_pkg::*;
#(
    parameter int unsigned MAX_OUT = MaxOutDefault,
    parameter int unsigned CNT_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid_i,
    input  logic [4:0]  id_rs1_idx_i,
    input  logic [4:0]  id_rs2_idx_i,
    input  logic [4:0]  id_rd_idx_i,
    input  logic        id_wben_i,
    input  logic        id_long_i,
    input  logic        id_fence_i,
    input  logic        ex_ready_i,
    input  logic        redirect_i,
    output logic        issue_o,
    output logic        stalln_pc_o,
    output logic        stalln_id_o,
    output logic        flush_id_o,
    input  logic        alu_wren_i,
    input  logic [4:0]  alu_rd_i,
    input  logic [63:0] alu_data_i,
    input  logic        lsu_wb_valid_i,
    output logic        lsu_wb_ready_o,
    input  logic [4:0]  lsu_rd_i,
    input  logic [63:0] lsu_data_i,
    input  logic        md_wb_valid_i,
    output logic        md_wb_ready_o,
    input  logic [4:0]  md_rd_i,
    input  logic [63:0] md_data_i,
    output logic        wb_wren_o,
    output logic [4:0]  wb_rdid_o,
    output logic [63:0] wb_data_o,
    output logic [31:0] perf_raw_o,
    output logic [31:0] perf_full_o,
    output logic [31:0] perf_drain_o
);

    sched_state_e     r_state, w_state_d;
    logic [31:1]      r_pend;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic [31:0]      w_pend, w_pend_n;
    logic             w_hazard, w_full, w_cnt_nz;
    logic             w_set, w_clr;
    logic [4:0]       w_clr_idx;
    logic             w_gnt_alu, w_gnt_lsu, w_gnt_mdu;
    logic [1:0]       w_sel;

    assign w_pend   = {r_pend, 1'b0};
    assign w_cnt_nz = (r_cnt != '0);
    assign w_hazard = w_pend[id_rs1_idx_i] | w_pend[id_rs2_idx_i] |
                      (id_wben_i & w_pend[id_rd_idx_i]);
    assign w_full   = id_long_i & id_wben_i & (r_cnt == CNT_W'(MAX_OUT));

    always_comb begin
        w_state_d  = r_state;
        issue_o    = 1'b0;
        flush_id_o = 1'b0;
        case (r_state)
            SchedRun: begin
                issue_o = id_valid_i & ex_ready_i & ~w_hazard & ~w_full &
                          ~(id_fence_i & w_cnt_nz);
                if (id_fence_i & id_valid_i & w_cnt_nz) begin
                    w_state_d = SchedDrain;
                end
            end
            SchedDrain: begin
                if (!w_cnt_nz) begin
                    w_state_d = SchedRun;
                end
            end
            SchedFlush: w_state_d = SchedRun;
            default:    w_state_d = SchedRun;
        endcase
        // Redirect overrides drain and issue in every state.
        if (redirect_i) begin
            issue_o    = 1'b0;
            flush_id_o = 1'b1;
            w_state_d  = SchedFlush;
        end
    end

    assign stalln_pc_o = ~(id_valid_i & ~issue_o & ~redirect_i);
    assign stalln_id_o = stalln_pc_o;

    wb_rr_arb u_wb_rr_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_hp_req (alu_wren_i),
        .i_req_a  (lsu_wb_valid_i),
        .i_req_b  (md_wb_valid_i),
        .o_gnt_hp (w_gnt_alu),
        .o_gnt_a  (w_gnt_lsu),
        .o_gnt_b  (w_gnt_mdu),
        .o_sel    (w_sel)
    );

    assign lsu_wb_ready_o = w_gnt_lsu;
    assign md_wb_ready_o  = w_gnt_mdu;
    assign wb_wren_o      = w_gnt_alu | w_gnt_lsu | w_gnt_mdu;

    always_comb begin
        wb_rdid_o = alu_rd_i;
        wb_data_o = alu_data_i;
        case (w_sel)
            WbSelLsu: begin
                wb_rdid_o = lsu_rd_i;
                wb_data_o = lsu_data_i;
            end
            WbSelMdu: begin
                wb_rdid_o = md_rd_i;
                wb_data_o = md_data_i;
            end
            default: ;
        endcase
    end

    // A grant for an index that is not pending (e.g. issued before reset) leaves state alone.
    assign w_set     = issue_o & id_long_i & id_wben_i & (id_rd_idx_i != 5'd0);
    assign w_clr_idx = w_gnt_mdu ? md_rd_i : lsu_rd_i;
    assign w_clr     = (w_gnt_lsu | w_gnt_mdu) & w_pend[w_clr_idx];

    always_comb begin
        w_pend_n = w_pend;
        if (w_clr) begin
            w_pend_n[w_clr_idx] = 1'b0;
        end
        if (w_set) begin
            w_pend_n[id_rd_idx_i] = 1'b1;
        end
        w_cnt_d = r_cnt + CNT_W'(w_set) - CNT_W'(w_clr);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= SchedRun;
            r_pend  <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_pend  <= w_pend_n[31:1];
            r_cnt   <= w_cnt_d;
        end
    end

`ifdef ISSUE_SCHED_PERF_EN
    logic [31:0] r_perf_raw, r_perf_full, r_perf_drain;
    logic        w_raw_ev, w_full_ev, w_drain_ev;

    assign w_raw_ev   = id_valid_i & w_hazard & (r_state == SchedRun);
    assign w_full_ev  = id_valid_i & w_full & (r_state == SchedRun);
    assign w_drain_ev = (r_state == SchedDrain);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_perf_raw   <= '0;
            r_perf_full  <= '0;
            r_perf_drain <= '0;
        end else begin
            if (w_raw_ev && r_perf_raw != '1) r_perf_raw <= r_perf_raw + 32'd1;
            if (w_full_ev && r_perf_full != '1) r_perf_full <= r_perf_full + 32'd1;
            if (w_drain_ev && r_perf_drain != '1) r_perf_drain <= r_perf_drain + 32'd1;
        end
    end

    assign perf_raw_o   = r_perf_raw;
    assign perf_full_o  = r_perf_full;
    assign perf_drain_o = r_perf_drain;
`else
    assign perf_raw_o   = '0;
    assign perf_full_o  = '0;
    assign perf_drain_o = '0;
`endif

endmodule

// File: tb/tb_issue_sched.sv
// Directed bench for issue_sched with a writeback scoreboard queue.
module tb_issue_sched;

`ifdef ISSUE_SCHED_PERF_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid_i, id_wben_i, id_long_i, id_fence_i, ex_ready_i, redirect_i;
    logic [4:0]  id_rs1_idx_i, id_rs2_idx_i, id_rd_idx_i;
    logic        issue_o, stalln_pc_o, stalln_id_o, flush_id_o;
    logic        alu_wren_i, lsu_wb_valid_i, md_wb_valid_i;
    logic [4:0]  alu_rd_i, lsu_rd_i, md_rd_i;
    logic [63:0] alu_data_i, lsu_data_i, md_data_i;
    logic        lsu_wb_ready_o, md_wb_ready_o, wb_wren_o;
    logic [4:0]  wb_rdid_o;
    logic [63:0] wb_data_o;
    logic [31:0] perf_raw_o, perf_full_o, perf_drain_o;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } wb_exp_t;

    wb_exp_t sb_q[$];
    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    issue_sched dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_valid_i     (id_valid_i),
        .id_rs1_idx_i   (id_rs1_idx_i),
        .id_rs2_idx_i   (id_rs2_idx_i),
        .id_rd_idx_i    (id_rd_idx_i),
        .id_wben_i      (id_wben_i),
        .id_long_i      (id_long_i),
        .id_fence_i     (id_fence_i),
        .ex_ready_i     (ex_ready_i),
        .redirect_i     (redirect_i),
        .issue_o        (issue_o),
        .stalln_pc_o    (stalln_pc_o),
        .stalln_id_o    (stalln_id_o),
        .flush_id_o     (flush_id_o),
        .alu_wren_i     (alu_wren_i),
        .alu_rd_i       (alu_rd_i),
        .alu_data_i     (alu_data_i),
        .lsu_wb_valid_i (lsu_wb_valid_i),
        .lsu_wb_ready_o (lsu_wb_ready_o),
        .lsu_rd_i       (lsu_rd_i),
        .lsu_data_i     (lsu_data_i),
        .md_wb_valid_i  (md_wb_valid_i),
        .md_wb_ready_o  (md_wb_ready_o),
        .md_rd_i        (md_rd_i),
        .md_data_i      (md_data_i),
        .wb_wren_o      (wb_wren_o),
        .wb_rdid_o      (wb_rdid_o),
        .wb_data_o      (wb_data_o),
        .perf_raw_o     (perf_raw_o),
        .perf_full_o    (perf_full_o),
        .perf_drain_o   (perf_drain_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [4:0] rd, input logic [63:0] data);
        wb_exp_t e;
        e.rd   = rd;
        e.data = data;
        sb_q.push_back(e);
    endtask

    task automatic settle();
        #1;
    endtask

    // Retire any regfile write against the scoreboard, then advance one clock.
    task automatic tick();
        wb_exp_t e;
        #1;
        if (wb_wren_o) begin
            chk("sb_write_expected", 64'(sb_q.size() > 0), 64'd1);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sb_rd", 64'(wb_rdid_o), 64'(e.rd));
                chk("sb_data", wb_data_o, e.data);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                            input logic [4:0] rd, input logic wben, input logic lng,
                            input logic fence);
        id_valid_i   = v;
        id_rs1_idx_i = rs1;
        id_rs2_idx_i = rs2;
        id_rd_idx_i  = rd;
        id_wben_i    = wben;
        id_long_i    = lng;
        id_fence_i   = fence;
    endtask

    task automatic idle();
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
        ex_ready_i     = 1'b1;
        redirect_i     = 1'b0;
        alu_wren_i     = 1'b0;
        alu_rd_i       = 5'd0;
        alu_data_i     = '0;
        lsu_wb_valid_i = 1'b0;
        lsu_rd_i       = 5'd0;
        lsu_data_i     = '0;
        md_wb_valid_i  = 1'b0;
        md_rd_i        = 5'd0;
        md_data_i      = '0;
    endtask

    initial begin
        idle();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        settle();
        chk("rst_issue", 64'(issue_o), 64'd0);
        chk("rst_stalln_pc", 64'(stalln_pc_o), 64'd1);
        chk("rst_stalln_id", 64'(stalln_id_o), 64'd1);
        chk("rst_flush", 64'(flush_id_o), 64'd0);
        chk("rst_wren", 64'(wb_wren_o), 64'd0);
        chk("rst_perf_raw", 64'(perf_raw_o), 64'd0);
        chk("rst_perf_full", 64'(perf_full_o), 64'd0);
        chk("rst_perf_drain", 64'(perf_drain_o), 64'd0);
        tick();

        // ALU override, then LSU, then MDU from the reset pointer.
        alu_wren_i = 1'b1; alu_rd_i = 5'd1; alu_data_i = 64'hA1A1_0000_0000_0001;
        lsu_wb_valid_i = 1'b1; lsu_rd_i = 5'd2; lsu_data_i = 64'h1111_2222_3333_4444;
        md_wb_valid_i = 1'b1; md_rd_i = 5'd3; md_data_i = 64'hDEAD_BEEF_0000_0003;
        push(5'd1, 64'hA1A1_0000_0000_0001);
        push(5'd2, 64'h1111_2222_3333_4444);
        push(5'd3, 64'hDEAD_BEEF_0000_0003);
        settle();
        chk("b_alu_lsu_ready", 64'(lsu_wb_ready_o), 64'd0);
        chk("b_alu_md_ready", 64'(md_wb_ready_o), 64'd0);
        tick();
        alu_wren_i = 1'b0;
        settle();
        chk("b_rr_lsu_ready", 64'(lsu_wb_ready_o), 64'd1);
        chk("b_rr_md_wait", 64'(md_wb_ready_o), 64'd0);
        tick();
        lsu_wb_valid_i = 1'b0;
        settle();
        chk("b_rr_md_ready", 64'(md_wb_ready_o), 64'd1);
        tick();
        md_wb_valid_i = 1'b0;

        // Load-use: load x5, consumer stalls until the LSU write retires.
        drive_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0);
        settle();
        chk("a_load_issue", 64'(issue_o), 64'd1);
        tick();
        drive_id(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
        settle();
        chk("a_raw_stall", 64'(issue_o), 64'd0);
        chk("a_raw_stalln_pc", 64'(stalln_pc_o), 64'd0);
        tick();
        lsu_wb_valid_i = 1'b1; lsu_rd_i = 5'd5; lsu_data_i = 64'h0000_0000_5555_5555;
        push(5'd5, 64'h0000_0000_5555_5555);
        settle();
        chk("a_clear_cycle_stall", 64'(issue_o), 64'd0);
        chk("a_lsu_ready", 64'(lsu_wb_ready_o), 64'd1);
        tick();
        lsu_wb_valid_i = 1'b0;
        settle();
        chk("a_issue_after_clear", 64'(issue_o), 64'd1);
        tick();
        idle();
        chk("a_perf_raw", 64'(perf_raw_o), PerfEn ? 64'd2 : 64'd0);

        // Outstanding limit: 4 loads issue, 5th stalls until a completion.
        for (int i = 0; i < 4; i++) begin
            drive_id(1'b1, 5'd0, 5'd0, 5'(10 + i), 1'b1, 1'b1, 1'b0);
            settle();
            chk("c_load_issue", 64'(issue_o), 64'd1);
            tick();
        end
        drive_id(1'b1, 5'd0, 5'd0, 5'd14, 1'b1, 1'b1, 1'b0);
        settle();
        chk("c_full_stall0", 64'(issue_o), 64'd0);
        tick();
        chk("c_full_stall1", 64'(issue_o), 64'd0);
        chk("c_perf_full1", 64'(perf_full_o), PerfEn ? 64'd1 : 64'd0);
        tick();
        lsu_wb_valid_i = 1'b1; lsu_rd_i = 5'd10; lsu_data_i = 64'h10;
        push(5'd10, 64'h10);
        settle();
        chk("c_full_clear_cycle", 64'(issue_o), 64'd0);
        tick();
        lsu_wb_valid_i = 1'b0;
        settle();
        chk("c_issue_after_completion", 64'(issue_o), 64'd1);
        tick();
        idle();
        chk("c_perf_full3", 64'(perf_full_o), PerfEn ? 64'd3 : 64'd0);
        // Pointer now favours MDU after the LSU grant.
        lsu_wb_valid_i = 1'b1; lsu_rd_i = 5'd11; lsu_data_i = 64'h11;
        md_wb_valid_i = 1'b1; md_rd_i = 5'd12; md_data_i = 64'h12;
        push(5'd12, 64'h12);
        push(5'd11, 64'h11);
        settle();
        chk("c_rr_md_first", 64'(md_wb_ready_o), 64'd1);
        chk("c_rr_lsu_hold", 64'(lsu_wb_ready_o), 64'd0);
        tick();
        md_wb_valid_i = 1'b0;
        settle();
        chk("c_rr_lsu_next", 64'(lsu_wb_ready_o), 64'd1);
        tick();
        lsu_wb_valid_i = 1'b0;

        // Fence with two outstanding (x13, x14).
        drive_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        settle();
        chk("d_fence_hold", 64'(issue_o), 64'd0);
        tick();
        lsu_wb_valid_i = 1'b1; lsu_rd_i = 5'd13; lsu_data_i = 64'h13;
        push(5'd13, 64'h13);
        settle();
        chk("d_drain0", 64'(issue_o), 64'd0);
        chk("d_drain_stalln_id", 64'(stalln_id_o), 64'd0);
        tick();
        lsu_wb_valid_i = 1'b0;
        md_wb_valid_i = 1'b1; md_rd_i = 5'd14; md_data_i = 64'h14;
        push(5'd14, 64'h14);
        settle();
        chk("d_drain1", 64'(issue_o), 64'd0);
        tick();
        md_wb_valid_i = 1'b0;
        settle();
        chk("d_drain_cnt0", 64'(issue_o), 64'd0);
        tick();
        chk("d_fence_issue", 64'(issue_o), 64'd1);
        tick();
        idle();
        chk("d_perf_drain", 64'(perf_drain_o), PerfEn ? 64'd3 : 64'd0);

        // Redirect while draining.
        drive_id(1'b1, 5'd0, 5'd0, 5'd20, 1'b1, 1'b1, 1'b0);
        settle();
        chk("e_load_issue", 64'(issue_o), 64'd1);
        tick();
        drive_id(1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
        tick();
        redirect_i = 1'b1;
        settle();
        chk("e_flush", 64'(flush_id_o), 64'd1);
        chk("e_redirect_no_issue", 64'(issue_o), 64'd0);
        chk("e_redirect_stalln", 64'(stalln_pc_o), 64'd1);
        tick();
        redirect_i = 1'b0;
        settle();
        chk("e_flush_state_no_issue", 64'(issue_o), 64'd0);
        chk("e_flush_once", 64'(flush_id_o), 64'd0);
        tick();
        drive_id(1'b1, 5'd0, 5'd0, 5'd21, 1'b1, 1'b0, 1'b0);
        settle();
        chk("e_run_after_flush", 64'(issue_o), 64'd1);
        tick();
        idle();
        lsu_wb_valid_i = 1'b1; lsu_rd_i = 5'd20; lsu_data_i = 64'h20;
        push(5'd20, 64'h20);
        tick();
        lsu_wb_valid_i = 1'b0;
        chk("e_perf_drain", 64'(perf_drain_o), PerfEn ? 64'd4 : 64'd0);

        // x0 writes pass through.
        alu_wren_i = 1'b1; alu_rd_i = 5'd0; alu_data_i = 64'hFFFF_0000_FFFF_0000;
        push(5'd0, 64'hFFFF_0000_FFFF_0000);
        settle();
        chk("x0_wren", 64'(wb_wren_o), 64'd1);
        tick();
        alu_wren_i = 1'b0;

        // Result arriving after reset must not underflow the counter.
        drive_id(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
        settle();
        chk("f_load_issue", 64'(issue_o), 64'd1);
        tick();
        idle();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        settle();
        chk("f_perf_reset", 64'(perf_drain_o), 64'd0);
        md_wb_valid_i = 1'b1; md_rd_i = 5'd7; md_data_i = 64'h7777;
        push(5'd7, 64'h7777);
        settle();
        chk("f_md_ready", 64'(md_wb_ready_o), 64'd1);
        chk("f_wren", 64'(wb_wren_o), 64'd1);
        tick();
        md_wb_valid_i = 1'b0;
        drive_id(1'b1, 5'd7, 5'd0, 5'd8, 1'b1, 1'b0, 1'b0);
        settle();
        chk("f_pend7_clear", 64'(issue_o), 64'd1);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive_id(1'b1, 5'd0, 5'd0, 5'(21 + i), 1'b1, 1'b1, 1'b0);
            settle();
            chk("f_load_issue_n", 64'(issue_o), 64'd1);
            tick();
        end
        drive_id(1'b1, 5'd0, 5'd0, 5'd25, 1'b1, 1'b1, 1'b0);
        settle();
        chk("f_cnt_no_underflow", 64'(issue_o), 64'd0);
        tick();
        idle();

        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
